// File: rtl/eightbit_adder_pkg.sv
// Shared constants for the registered 8-bit ripple-carry adder.
package eightbit_adder_pkg;

    localparam int unsigned ADDER_W = 8;
    localparam logic [ADDER_W-1:0] SumRst = 8'h00;

endpackage

// File: rtl/eightbit_adder_full_adder.sv
// Gate-level one-bit full adder; purely combinational.
module eightbit_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // p is the propagate term, shared by the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/eightbit_adder.sv
// 8-bit ripple-carry adder with carry-in, carry-out and signed overflow,
// results registered one clock after the operands are sampled.
module eightbit_adder
    import eightbit_adder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDER_W-1:0] A,
    input  logic [ADDER_W-1:0] B,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout,
    output logic               overflow
);

    logic [ADDER_W:0]   c;
    logic [ADDER_W-1:0] s;

    logic [ADDER_W-1:0] sum_d, sum_q;
    logic               cout_d, cout_q;
    logic               overflow_d, overflow_q;

    assign c[0] = cin;

    for (genvar i = 0; i < ADDER_W; i++) begin : g_bit
        eightbit_adder_full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_comb begin
        sum_d      = s;
        cout_d     = c[ADDER_W];
        // Signed overflow: carry into the sign bit differs from carry out of it.
        overflow_d = c[ADDER_W] ^ c[ADDER_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= SumRst;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_eightbit_adder.sv
// Directed and random checks of the registered 8-bit adder, including
// asynchronous reset behaviour and one-cycle latency.
module tb_eightbit_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    eightbit_adder u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Observed/expected packed as {cout, overflow, sum}.
    task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got cout=%b ovf=%b sum=%h, expected cout=%b ovf=%b sum=%h",
                     tag, obs[9], obs[8], obs[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        A   = a;
        B   = b;
        cin = ci;
    endtask

    task automatic edge_check(input string tag, input logic [9:0] exp);
        @(posedge clk);
        #1;
        check_val(tag, {cout, overflow, sum}, exp);
    endtask

    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [8:0] r;
        logic       ovf;
        r   = {1'b0, a} + {1'b0, b} + {8'h00, ci};
        ovf = (a[7] == b[7]) && (r[7] != a[7]);
        return {r[8], ovf, r[7:0]};
    endfunction

    initial begin
        rst_n = 1'b0;
        A     = 8'hFF;
        B     = 8'h01;
        cin   = 1'b0;

        // Reset held with clock running.
        edge_check("reset_hold0", 10'b0_0_00000000);
        edge_check("reset_hold1", 10'b0_0_00000000);

        @(negedge clk);
        rst_n = 1'b1;
        edge_check("first_capture", 10'b1_0_00000000);

        drive(8'h36, 8'h0F, 1'b0);
        edge_check("add_36_0f", 10'b0_0_01000101);

        drive(8'h40, 8'h40, 1'b0);
        // Before the edge the previous result must still be held.
        check_val("latency_hold", {cout, overflow, sum}, 10'b0_0_01000101);
        edge_check("add_40_40", 10'b0_1_10000000);

        drive(8'hB3, 8'h4D, 1'b0);
        edge_check("add_b3_4d", 10'b1_0_00000000);

        drive(8'h80, 8'h80, 1'b0);
        edge_check("add_80_80", 10'b1_1_00000000);

        drive(8'h10, ~8'h01, 1'b1);
        edge_check("sub_10_01", 10'b1_0_00001111);

        drive(8'hFF, 8'h00, 1'b1);
        edge_check("wrap_ff_cin", 10'b1_0_00000000);

        drive(8'h7F, 8'h01, 1'b0);
        edge_check("add_7f_01", 10'b0_1_10000000);

        // Back-to-back operations on consecutive edges.
        drive(8'h01, 8'h02, 1'b0);
        edge_check("b2b_0", 10'b0_0_00000011);
        drive(8'hF0, 8'h0F, 1'b1);
        edge_check("b2b_1", 10'b1_0_00000000);
        drive(8'h81, 8'hFE, 1'b0);
        edge_check("b2b_2", 10'b1_1_01111111);

        // Asynchronous reset mid-stream.
        drive(8'h36, 8'h0F, 1'b0);
        edge_check("pre_async", 10'b0_0_01000101);
        drive(8'h11, 8'h22, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_clear", {cout, overflow, sum}, 10'b0_0_00000000);
        edge_check("async_held", 10'b0_0_00000000);
        @(negedge clk);
        rst_n = 1'b1;
        edge_check("post_async", 10'b0_0_00110011);

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            drive(ra, rb, rc);
            edge_check($sformatf("rand_%0d", i), model(ra, rb, rc));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
